// File: rtl/cajero_pkg.sv
// Shared definitions for the cashier controller: FSM state encoding,
// transaction type codes, datapath widths and the captured transaction payload.
package cajero_pkg;

    localparam int unsigned PIN_W     = 16;
    localparam int unsigned MONTO_W   = 32;
    localparam int unsigned BALANCE_W = 64;
    localparam int unsigned SUMA_W    = BALANCE_W + 1;
    localparam int unsigned IDLE_W    = 16;

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        INGRESO_PIN    = 3'd1,
        VERIFICAR_PIN  = 3'd2,
        ESPERA_MONTO   = 3'd3,
        PROCESAR       = 3'd4,
        FIN_TRANS      = 3'd5,
        BLOQUEO        = 3'd6
    } estado_e;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Transaction captured on monto_stb.
    typedef struct packed {
        logic               tipo;
        logic [MONTO_W-1:0] monto;
    } trans_t;

    // Balance plus zero-extended amount, clamped at the all-ones balance.
    function automatic logic [BALANCE_W-1:0] suma_saturada(
        input logic [BALANCE_W-1:0] a,
        input logic [MONTO_W-1:0]   b
    );
        logic [SUMA_W-1:0] s;
        s = {1'b0, a} + SUMA_W'(b);
        return s[BALANCE_W] ? {BALANCE_W{1'b1}} : s[BALANCE_W-1:0];
    endfunction

endpackage

// File: rtl/cajero_captura_pin.sv
// PIN capture: 16-bit shift register of BCD digits (first digit ends up in
// the top nibble) plus a 2-bit digit counter.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   limpiar         - clear register and counter (has priority over desplazar)
//   desplazar       - shift digito in and count it
//   digito          - BCD digit
//   pin             - captured PIN
//   completo_c      - combinational: this shift is the 4th digit
module cajero_captura_pin
    import cajero_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             limpiar,
    input  logic             desplazar,
    input  logic [3:0]       digito,
    output logic [PIN_W-1:0] pin,
    output logic             completo_c
);

    logic [PIN_W-1:0] pin_q, pin_d;
    logic [1:0]       cuenta_q, cuenta_d;

    // Shift/count next state; the counter wraps to 0 on the 4th digit.
    always_comb begin
        pin_d    = pin_q;
        cuenta_d = cuenta_q;
        if (limpiar) begin
            pin_d    = '0;
            cuenta_d = '0;
        end else if (desplazar) begin
            pin_d    = {pin_q[PIN_W-5:0], digito};
            cuenta_d = cuenta_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pin_q    <= '0;
            cuenta_q <= '0;
        end else begin
            pin_q    <= pin_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign pin        = pin_q;
    assign completo_c = desplazar && (cuenta_q == 2'd3);

endmodule

// File: rtl/cajero_controlador.sv
// Cashier main sequencer: card acceptance, PIN entry with attempt limit and
// blocking, then one deposit or withdrawal on the stored balance.
// Optional idle timeout in PIN entry / amount wait: define CAJERO_TIMEOUT_EN.
// Ports:
//   clk, reset                     - clock, asynchronous active-low reset
//   tarjeta_recibida               - card present (looked at only while idle)
//   digito_stb, digito             - PIN digit strobe and BCD digit
//   monto_stb, monto, tipo_trans   - amount strobe, amount, 0 deposit / 1 withdrawal
//   balance                        - account balance
//   pin_incorrecto                 - pulse per wrong PIN
//   advertencia                    - level, one attempt left
//   bloqueo                        - sticky block until reset
//   entregar_dinero                - pulse, withdrawal approved
//   fondos_insuficientes           - pulse, withdrawal rejected
//   fin                            - pulse, transaction complete
module cajero_controlador
    import cajero_pkg::*;
#(
    parameter logic [PIN_W-1:0]     PIN_CORRECTO    = 16'h1234,
    parameter int unsigned          MAX_INTENTOS    = 3,
    parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = 64'd1000,
    parameter int unsigned          TIMEOUT_CICLOS  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tarjeta_recibida,
    input  logic                 digito_stb,
    input  logic [3:0]           digito,
    input  logic                 monto_stb,
    input  logic [MONTO_W-1:0]   monto,
    input  logic                 tipo_trans,
    output logic [BALANCE_W-1:0] balance,
    output logic                 pin_incorrecto,
    output logic                 advertencia,
    output logic                 bloqueo,
    output logic                 entregar_dinero,
    output logic                 fondos_insuficientes,
    output logic                 fin
);

    localparam int unsigned INT_W = $clog2(MAX_INTENTOS + 1);

    estado_e              state_q, state_d;
    logic [INT_W-1:0]     intentos_q, intentos_d;
    logic [BALANCE_W-1:0] balance_q, balance_d;
    trans_t               trans_q, trans_d;
    logic                 pin_incorrecto_q, pin_incorrecto_d;
    logic                 advertencia_q, advertencia_d;
    logic                 bloqueo_q, bloqueo_d;
    logic                 entregar_q, entregar_d;
    logic                 fondos_q, fondos_d;
    logic                 fin_q, fin_d;

    logic                 limpiar_c;
    logic                 desplazar_c;
    logic                 completo_c;
    logic                 timeout_c;
    logic [PIN_W-1:0]     pin_c;

    assign desplazar_c = digito_stb && (state_q == INGRESO_PIN);

    cajero_captura_pin u_captura (
        .clk        (clk),
        .reset      (reset),
        .limpiar    (limpiar_c),
        .desplazar  (desplazar_c),
        .digito     (digito),
        .pin        (pin_c),
        .completo_c (completo_c)
    );

`ifdef CAJERO_TIMEOUT_EN
    // Idle counter: restarts on state entry and on every accepted strobe.
    logic [IDLE_W-1:0] ocio_q, ocio_d;
    logic              espera_c;
    logic              acepta_c;

    assign espera_c  = (state_q == INGRESO_PIN) || (state_q == ESPERA_MONTO);
    assign acepta_c  = ((state_q == INGRESO_PIN) && digito_stb) ||
                       ((state_q == ESPERA_MONTO) && monto_stb);
    assign timeout_c = espera_c && !acepta_c &&
                       (ocio_q == IDLE_W'(TIMEOUT_CICLOS - 1));

    always_comb begin
        ocio_d = '0;
        if (espera_c && !acepta_c && (state_d == state_q)) begin
            ocio_d = ocio_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocio_q <= '0;
        end else begin
            ocio_q <= ocio_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CICLOS;
    assign timeout_c      = 1'b0;
`endif

    // Next state, datapath and registered outputs.
    always_comb begin
        state_d          = state_q;
        intentos_d       = intentos_q;
        balance_d        = balance_q;
        trans_d          = trans_q;
        bloqueo_d        = bloqueo_q;
        pin_incorrecto_d = 1'b0;
        entregar_d       = 1'b0;
        fondos_d         = 1'b0;
        fin_d            = 1'b0;
        limpiar_c        = 1'b0;

        case (state_q)
            ESPERA_TARJETA: begin
                if (tarjeta_recibida) begin
                    state_d   = INGRESO_PIN;
                    limpiar_c = 1'b1;
                end
            end
            INGRESO_PIN: begin
                if (completo_c) begin
                    state_d = VERIFICAR_PIN;
                end else if (timeout_c) begin
                    state_d   = FIN_TRANS;
                    limpiar_c = 1'b1;
                end
            end
            VERIFICAR_PIN: begin
                if (pin_c == PIN_CORRECTO) begin
                    state_d    = ESPERA_MONTO;
                    intentos_d = '0;
                end else begin
                    intentos_d       = intentos_q + INT_W'(1);
                    pin_incorrecto_d = 1'b1;
                    if (intentos_d == INT_W'(MAX_INTENTOS)) begin
                        state_d   = BLOQUEO;
                        bloqueo_d = 1'b1;
                    end else begin
                        state_d   = INGRESO_PIN;
                        limpiar_c = 1'b1;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (monto_stb) begin
                    trans_d.tipo  = tipo_trans;
                    trans_d.monto = monto;
                    state_d       = PROCESAR;
                end else if (timeout_c) begin
                    state_d = FIN_TRANS;
                end
            end
            PROCESAR: begin
                if (trans_q.tipo == DEPOSITO) begin
                    balance_d = suma_saturada(balance_q, trans_q.monto);
                end else if (BALANCE_W'(trans_q.monto) > balance_q) begin
                    fondos_d = 1'b1;
                end else begin
                    balance_d  = balance_q - BALANCE_W'(trans_q.monto);
                    entregar_d = 1'b1;
                end
                state_d = FIN_TRANS;
            end
            FIN_TRANS: begin
                fin_d   = 1'b1;
                state_d = ESPERA_TARJETA;
            end
            BLOQUEO: begin
                bloqueo_d = 1'b1;
            end
            default: begin
                state_d = ESPERA_TARJETA;
            end
        endcase

        // Warning tracks the attempt count it will show next cycle.
        advertencia_d = (intentos_d == INT_W'(MAX_INTENTOS - 1)) && (state_d != BLOQUEO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ESPERA_TARJETA;
            intentos_q       <= '0;
            balance_q        <= BALANCE_INICIAL;
            trans_q          <= '0;
            pin_incorrecto_q <= 1'b0;
            advertencia_q    <= 1'b0;
            bloqueo_q        <= 1'b0;
            entregar_q       <= 1'b0;
            fondos_q         <= 1'b0;
            fin_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            intentos_q       <= intentos_d;
            balance_q        <= balance_d;
            trans_q          <= trans_d;
            pin_incorrecto_q <= pin_incorrecto_d;
            advertencia_q    <= advertencia_d;
            bloqueo_q        <= bloqueo_d;
            entregar_q       <= entregar_d;
            fondos_q         <= fondos_d;
            fin_q            <= fin_d;
        end
    end

    assign balance              = balance_q;
    assign pin_incorrecto       = pin_incorrecto_q;
    assign advertencia          = advertencia_q;
    assign bloqueo              = bloqueo_q;
    assign entregar_dinero      = entregar_q;
    assign fondos_insuficientes = fondos_q;
    assign fin                  = fin_q;

endmodule
